// File: rtl/ddr2_fifo_responder.sv
// Behavioural DDR2 back-end stand-in: af/wdf command and write-data FIFOs in, rdf read beats out.
// Serves line fills and write-backs from on-chip storage with a fixed, programmable read latency.
module ddr2_fifo_responder #(
    parameter int LINE_BITS   = 7,
    parameter int RD_LATENCY  = 8,
    parameter int AF_DEPTH    = 4,
    parameter int WDF_DEPTH   = 8,
    parameter int INIT_CYCLES = 16
) (
    input  logic         cpu_clk_g,
    input  logic         rst,
    output logic         init_done,
    input  logic [2:0]   af_cmd_din,
    input  logic [30:0]  af_addr_din,
    input  logic         af_wr_en,
    output logic         af_full,
    input  logic [127:0] wdf_din,
    input  logic [15:0]  wdf_mask_din,
    input  logic         wdf_wr_en,
    output logic         wdf_full,
    output logic [127:0] rdf_dout,
    output logic         rdf_valid,
    output logic         err
);

    // state    | meaning
    // ---------+-----------------------------------------------
    // IDLE     | waiting for an af entry; pops and decodes it
    // RD_WAIT  | read latency down-counter running
    // RD_B0    | beat 0 on rdf_dout, rdf_valid high
    // RD_B1    | beat 1 on rdf_dout, rdf_valid high
    // WR_WAIT  | write popped, waiting for two wdf beats
    // WR_B0    | popping and storing beat 0
    // WR_B1    | popping and storing beat 1
    typedef enum logic [2:0] {
        S_IDLE, S_RD_WAIT, S_RD_B0, S_RD_B1, S_WR_WAIT, S_WR_B0, S_WR_B1
    } state_t;

    localparam int AF_AW  = $clog2(AF_DEPTH);
    localparam int WDF_AW = $clog2(WDF_DEPTH);
    localparam int AF_W   = 3 + LINE_BITS + 3;
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int NLINES = 2 ** LINE_BITS;

    localparam logic [2:0] CMD_RD = 3'b001;
    localparam logic [2:0] CMD_WR = 3'b000;

    state_t               state;
    logic [7:0]           lat_cnt;
    logic [LINE_BITS-1:0] cur_line;
    logic [INIT_W-1:0]    init_cnt;
    logic                 init_done_nxt;

    // Upper address bits only alias; they never reach storage.
    logic addr_hi_unused;
    assign addr_hi_unused = ^af_addr_din[30:LINE_BITS+3];

    // ---------------- init sequencing ----------------
    assign init_done_nxt = init_done | (init_cnt == INIT_W'(INIT_CYCLES - 1));

    always_ff @(posedge cpu_clk_g or posedge rst) begin
        if (rst) begin
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else if (!init_done) begin
            init_cnt  <= init_cnt + 1'b1;
            init_done <= init_done_nxt;
        end
    end

    // ---------------- address/command FIFO ----------------
    logic [AF_W-1:0]  af_mem [AF_DEPTH];
    logic [AF_AW:0]   af_wr_ptr, af_rd_ptr, af_wr_ptr_nxt, af_rd_ptr_nxt, af_count;
    logic [AF_W-1:0]  af_head;
    logic [2:0]       head_cmd;
    logic [LINE_BITS+2:0] head_addr;
    logic             af_push, af_pop, head_bad;

    assign af_push   = af_wr_en & ~af_full;
    assign af_count  = af_wr_ptr - af_rd_ptr;
    assign af_pop    = (state == S_IDLE) && (af_count != '0);
    assign af_head   = af_mem[af_rd_ptr[AF_AW-1:0]];
    assign head_cmd  = af_head[AF_W-1 -: 3];
    assign head_addr = af_head[LINE_BITS+2:0];
    assign head_bad  = (head_addr[2:0] != 3'b000) ||
                       ((head_cmd != CMD_RD) && (head_cmd != CMD_WR));

    assign af_wr_ptr_nxt = af_wr_ptr + {{AF_AW{1'b0}}, af_push};
    assign af_rd_ptr_nxt = af_rd_ptr + {{AF_AW{1'b0}}, af_pop};

    always_ff @(posedge cpu_clk_g) begin
        if (af_push)
            af_mem[af_wr_ptr[AF_AW-1:0]] <= {af_cmd_din, af_addr_din[LINE_BITS+2:0]};
    end

    always_ff @(posedge cpu_clk_g or posedge rst) begin
        if (rst) begin
            af_wr_ptr <= '0;
            af_rd_ptr <= '0;
            af_full   <= 1'b1;
        end else begin
            af_wr_ptr <= af_wr_ptr_nxt;
            af_rd_ptr <= af_rd_ptr_nxt;
            af_full   <= ((af_wr_ptr_nxt - af_rd_ptr_nxt) == (AF_AW+1)'(AF_DEPTH)) | ~init_done_nxt;
        end
    end

    // ---------------- write-data FIFO ----------------
    logic [143:0]     wdf_mem [WDF_DEPTH];
    logic [WDF_AW:0]  wdf_wr_ptr, wdf_rd_ptr, wdf_wr_ptr_nxt, wdf_rd_ptr_nxt, wdf_count;
    logic [143:0]     wdf_head;
    logic [127:0]     wdf_head_data;
    logic [15:0]      wdf_head_mask;
    logic             wdf_push, wdf_pop;

    assign wdf_push      = wdf_wr_en & ~wdf_full;
    assign wdf_pop       = (state == S_WR_B0) || (state == S_WR_B1);
    assign wdf_count     = wdf_wr_ptr - wdf_rd_ptr;
    assign wdf_head      = wdf_mem[wdf_rd_ptr[WDF_AW-1:0]];
    assign wdf_head_mask = wdf_head[143:128];
    assign wdf_head_data = wdf_head[127:0];

    assign wdf_wr_ptr_nxt = wdf_wr_ptr + {{WDF_AW{1'b0}}, wdf_push};
    assign wdf_rd_ptr_nxt = wdf_rd_ptr + {{WDF_AW{1'b0}}, wdf_pop};

    always_ff @(posedge cpu_clk_g) begin
        if (wdf_push)
            wdf_mem[wdf_wr_ptr[WDF_AW-1:0]] <= {wdf_mask_din, wdf_din};
    end

    always_ff @(posedge cpu_clk_g or posedge rst) begin
        if (rst) begin
            wdf_wr_ptr <= '0;
            wdf_rd_ptr <= '0;
            wdf_full   <= 1'b1;
        end else begin
            wdf_wr_ptr <= wdf_wr_ptr_nxt;
            wdf_rd_ptr <= wdf_rd_ptr_nxt;
            wdf_full   <= ((wdf_wr_ptr_nxt - wdf_rd_ptr_nxt) == (WDF_AW+1)'(WDF_DEPTH)) | ~init_done_nxt;
        end
    end

    // ---------------- line storage (not reset, survives rst) ----------------
    logic [127:0] line_mem [NLINES*2];

    always_ff @(posedge cpu_clk_g) begin
        if (wdf_pop) begin
            for (int b = 0; b < 16; b++) begin
                if (!wdf_head_mask[b])
                    line_mem[{cur_line, state == S_WR_B1}][8*b +: 8] <= wdf_head_data[8*b +: 8];
            end
        end
    end

    // ---------------- command sequencer ----------------
    logic push_err;
    assign push_err = (af_wr_en & af_full) | (wdf_wr_en & wdf_full);

    always_ff @(posedge cpu_clk_g or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            lat_cnt   <= '0;
            cur_line  <= '0;
            rdf_valid <= 1'b0;
            rdf_dout  <= '0;
            err       <= 1'b0;
        end else begin
            rdf_valid <= 1'b0;
            err       <= err | push_err | (af_pop & head_bad);
            case (state)
                S_IDLE: begin
                    if (af_pop && !head_bad) begin
                        cur_line <= head_addr[LINE_BITS+2:3];
                        if (head_cmd == CMD_RD) begin
                            state   <= S_RD_WAIT;
                            lat_cnt <= 8'(RD_LATENCY - 1);
                        end else begin
                            state <= S_WR_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (lat_cnt == 8'd0) begin
                        state     <= S_RD_B0;
                        rdf_valid <= 1'b1;
                        rdf_dout  <= line_mem[{cur_line, 1'b0}];
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                S_RD_B0: begin
                    state     <= S_RD_B1;
                    rdf_valid <= 1'b1;
                    rdf_dout  <= line_mem[{cur_line, 1'b1}];
                end
                S_RD_B1:   state <= S_IDLE;
                S_WR_WAIT: begin
                    if (wdf_count >= (WDF_AW+1)'(2))
                        state <= S_WR_B0;
                end
                S_WR_B0:   state <= S_WR_B1;
                S_WR_B1:   state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

endmodule
